// File: rtl/rf_multiport_sb_pkg.sv
// Shared types and defaults for the multiport register file with scoreboard.
//   rf_state_e : RESET / CLEAR (zeroing sweep) / READY
//   RF_*       : default data width, register count, read port count
//   rf_aw(n)   : address width for an n-entry file
package rf_pkg;
  typedef enum logic [1:0] {RESET, CLEAR, READY} rf_state_e;

  localparam int RF_XLEN  = 32;
  localparam int RF_NREGS = 32;
  localparam int RF_NRP   = 2;

  function automatic int rf_aw(input int n);
    return $clog2(n);
  endfunction
endpackage

// File: rtl/rf_multiport_sb_if.sv
// Bus between issue/writeback and the register file.
//   re/rd_addr -> rd_data/rd_busy : NRP combinational read ports, packed
//   we/wr_addr/wr_data            : single write port
//   iss_v/iss_rd                  : mark destination busy at issue
//   ready                         : file usable (low during clear sweep)
// master = issue/writeback side, slave = register file.
interface rf_multiport_sb_if
  import rf_pkg::*;
#(
  parameter int XLEN  = RF_XLEN,
  parameter int NREGS = RF_NREGS,
  parameter int NRP   = RF_NRP
);
  localparam int AW = rf_aw(NREGS);

  logic [NRP-1:0]      re;
  logic [NRP*AW-1:0]   rd_addr;
  logic [NRP*XLEN-1:0] rd_data;
  logic [NRP-1:0]      rd_busy;
  logic                we;
  logic [AW-1:0]       wr_addr;
  logic [XLEN-1:0]     wr_data;
  logic                iss_v;
  logic [AW-1:0]       iss_rd;
  logic                ready;

  modport master (
    output re, rd_addr, we, wr_addr, wr_data, iss_v, iss_rd,
    input  rd_data, rd_busy, ready
  );
  modport slave (
    input  re, rd_addr, we, wr_addr, wr_data, iss_v, iss_rd,
    output rd_data, rd_busy, ready
  );
endinterface

// File: rtl/rf_multiport_sb_scoreboard.sv
// Per-register busy scoreboard.
//   en      : updates allowed (READY); when low all busy bits are cleared
//   we/wr_addr : writeback clears busy[wr_addr]
//   iss_v/iss_rd : issue sets busy[iss_rd]; set wins over clear
//   re/rd_addr -> rd_busy : per-port lookup, a write in flight un-busies
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NREGS = RF_NREGS,
  parameter int NRP   = RF_NRP,
  localparam int AW   = rf_aw(NREGS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    we,
  input  logic [AW-1:0]           wr_addr,
  input  logic                    iss_v,
  input  logic [AW-1:0]           iss_rd,
  input  logic [NRP-1:0]          re,
  input  logic [NRP-1:0][AW-1:0]  rd_addr,
  output logic [NRP-1:0]          rd_busy
);
  logic [NREGS-1:0] busy, busy_nx;

  always_comb begin
    busy_nx = busy;
    if (we && wr_addr != '0)    busy_nx[wr_addr] = 1'b0;
    if (iss_v && iss_rd != '0)  busy_nx[iss_rd]  = 1'b1;
    busy_nx[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst || !en) busy <= '0;
    else            busy <= busy_nx;
  end

  for (genvar i = 0; i < NRP; i++) begin : g_look
    assign rd_busy[i] = re[i] && (rd_addr[i] != '0) && busy[rd_addr[i]] &&
                        !(we && wr_addr == rd_addr[i]);
  end
endmodule

// File: rtl/rf_multiport_sb.sv
// Multiport register file: NRP combinational read ports with write-through
// bypass, one write port, x0 hardwired to zero, optional zeroing sweep after
// reset and a busy scoreboard for the issue stage.
//   clk, rst : clock, synchronous active-high reset
//   bus      : rf_multiport_sb_if slave (read/write/issue ports, ready)
module rf_multiport_sb
  import rf_pkg::*;
#(
  parameter int XLEN       = RF_XLEN,
  parameter int NREGS      = RF_NREGS,
  parameter int NRP        = RF_NRP,
  parameter int CLR_ON_RST = 1
) (
  input  logic            clk,
  input  logic            rst,
  rf_multiport_sb_if.slave bus
);
  localparam int AW = rf_aw(NREGS);

  rf_state_e state, state_nx;
  logic [AW-1:0] ptr, ptr_nx;
  logic [XLEN-1:0] mem [NREGS];

  logic rdy, wr_en, we_rdy;
  logic [NRP-1:0][AW-1:0]   ra;
  logic [NRP-1:0][XLEN-1:0] rd_d;

  assign rdy    = (state == READY);
  assign we_rdy = rdy & bus.we;
  assign wr_en  = we_rdy & (bus.wr_addr != '0);
  assign ra     = bus.rd_addr;

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    case (state)
      RESET: begin
        if (CLR_ON_RST != 0) begin
          state_nx = CLEAR;
          ptr_nx   = AW'(1);
        end else begin
          state_nx = READY;
        end
      end
      CLEAR: begin
        ptr_nx = ptr + AW'(1);
        if (ptr == AW'(NREGS-1)) state_nx = READY;
      end
      READY:   ;
      default: state_nx = RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RESET;
      ptr   <= '0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
    end
  end

  // Entry 0 is never written; reads of address 0 are forced to zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) mem[ptr]         <= '0;
      else if (wr_en)     mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  for (genvar i = 0; i < NRP; i++) begin : g_rd
    assign rd_d[i] = (!bus.re[i] || ra[i] == '0 || !rdy) ? '0 :
                     (wr_en && bus.wr_addr == ra[i])     ? bus.wr_data :
                                                           mem[ra[i]];
  end

  assign bus.rd_data = rd_d;
  assign bus.ready   = rdy;

  rf_scoreboard #(.NREGS(NREGS), .NRP(NRP)) u_sb (
    .clk     (clk),
    .rst     (rst),
    .en      (rdy),
    .we      (we_rdy),
    .wr_addr (bus.wr_addr),
    .iss_v   (bus.iss_v & rdy),
    .iss_rd  (bus.iss_rd),
    .re      (bus.re),
    .rd_addr (ra),
    .rd_busy (bus.rd_busy)
  );
endmodule

// File: tb/tb_rf_multiport_sb.sv
module tb_rf_multiport_sb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rf_multiport_sb_if #(.XLEN(32), .NREGS(32), .NRP(2)) b0 ();
  rf_multiport_sb_if #(.XLEN(32), .NREGS(32), .NRP(2)) b1 ();
  rf_multiport_sb_if #(.XLEN(64), .NREGS(16), .NRP(4)) b2 ();

  rf_multiport_sb #(.XLEN(32), .NREGS(32), .NRP(2), .CLR_ON_RST(1)) u0 (.clk(clk), .rst(rst), .bus(b0));
  rf_multiport_sb #(.XLEN(32), .NREGS(32), .NRP(2), .CLR_ON_RST(0)) u1 (.clk(clk), .rst(rst), .bus(b1));
  rf_multiport_sb #(.XLEN(64), .NREGS(16), .NRP(4), .CLR_ON_RST(1)) u2 (.clk(clk), .rst(rst), .bus(b2));

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  string       nm_q[$];

  task automatic push(input string nm, input logic [63:0] v);
    nm_q.push_back(nm);
    exp_q.push_back(v);
  endtask

  task automatic pop_check(input logic [63:0] obs);
    logic [63:0] e_;
    string n_;
    e_ = exp_q.pop_front();
    n_ = nm_q.pop_front();
    checks++;
    if (obs !== e_) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n_, obs, e_);
    end
  endtask

  function automatic logic [31:0] d0(input int p);
    return b0.rd_data[p*32 +: 32];
  endfunction
  function automatic logic [31:0] d1(input int p);
    return b1.rd_data[p*32 +: 32];
  endfunction
  function automatic logic [63:0] d2(input int p);
    return b2.rd_data[p*64 +: 64];
  endfunction

  task automatic idle();
    b0.re = '0; b0.rd_addr = '0; b0.we = 0; b0.wr_addr = '0; b0.wr_data = '0; b0.iss_v = 0; b0.iss_rd = '0;
    b1.re = '0; b1.rd_addr = '0; b1.we = 0; b1.wr_addr = '0; b1.wr_data = '0; b1.iss_v = 0; b1.iss_rd = '0;
    b2.re = '0; b2.rd_addr = '0; b2.we = 0; b2.wr_addr = '0; b2.wr_data = '0; b2.iss_v = 0; b2.iss_rd = '0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic count_sweep(output int z0, output int z1, output int z2);
    z0 = 0; z1 = 0; z2 = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (!b0.ready) z0++;
      if (!b1.ready) z1++;
      if (!b2.ready) z2++;
    end
  endtask

  task automatic wait_ready(input int lim);
    int n;
    n = 0;
    while (!(b0.ready && b1.ready && b2.ready) && n < lim) begin
      tick();
      n++;
    end
    checks++;
    if (!(b0.ready && b1.ready && b2.ready)) begin
      errors++;
      $display("FAIL wait_ready: timeout after %0d cycles", lim);
    end
  endtask

  task automatic test_reset();
    int z0, z1, z2;
    rst = 1'b1;
    tick(); tick();
    b0.re = 2'b11; b0.rd_addr = {5'd3, 5'd7};
    b0.iss_v = 1; b0.iss_rd = 5'd7;
    #1;
    push("rst_ready", 0);   pop_check(64'(b0.ready));
    push("rst_rd_data", 0); pop_check(64'(b0.rd_data));
    push("rst_rd_busy", 0); pop_check(64'(b0.rd_busy));
    idle();
    rst = 1'b0;
    count_sweep(z0, z1, z2);
    push("sweep_len_32", 31);   pop_check(64'(z0));
    push("sweep_len_noclr", 0); pop_check(64'(z1));
    push("sweep_len_16", 15);   pop_check(64'(z2));
    wait_ready(4);
    for (int a = 1; a < 32; a++) begin
      b0.re = 2'b11; b0.rd_addr = {5'(32 - a), 5'(a)};
      #1;
      push($sformatf("clr_r%0d", a), 0);         pop_check(64'(d0(0)));
      push($sformatf("clr_r%0d_p1", 32 - a), 0); pop_check(64'(d0(1)));
      tick();
    end
    for (int a = 1; a < 16; a++) begin
      b2.re = 4'b0001; b2.rd_addr = 16'(a);
      #1;
      push($sformatf("clr16_r%0d", a), 0); pop_check(64'(d2(0)));
      tick();
    end
    idle();
  endtask

  task automatic test_bypass();
    b0.we = 1; b0.wr_addr = 5'd5; b0.wr_data = 32'hDEADBEEF;
    b0.re = 2'b11; b0.rd_addr = {5'd5, 5'd5};
    #1;
    push("byp_p0", 32'hDEADBEEF); pop_check(64'(d0(0)));
    push("byp_p1", 32'hDEADBEEF); pop_check(64'(d0(1)));
    tick();
    b0.we = 0;
    #1;
    push("wr_p0", 32'hDEADBEEF); pop_check(64'(d0(0)));
    push("wr_p1", 32'hDEADBEEF); pop_check(64'(d0(1)));
    b0.we = 1; b0.wr_addr = 5'd0; b0.wr_data = 32'h1234; b0.rd_addr = {5'd5, 5'd0};
    #1;
    push("x0_byp", 0); pop_check(64'(d0(0)));
    tick();
    b0.we = 0;
    #1;
    push("x0_after", 0);          pop_check(64'(d0(0)));
    push("r5_kept", 32'hDEADBEEF); pop_check(64'(d0(1)));
    idle();
  endtask

  task automatic test_scoreboard();
    b0.iss_v = 1; b0.iss_rd = 5'd7; b0.re = 2'b01; b0.rd_addr = {5'd0, 5'd7};
    #1;
    push("busy7_pre", 0); pop_check(64'(b0.rd_busy[0]));
    tick();
    b0.iss_v = 0;
    #1;
    push("busy7_set", 1); pop_check(64'(b0.rd_busy[0]));
    b0.we = 1; b0.wr_addr = 5'd7; b0.wr_data = 32'h0000_0777;
    #1;
    push("busy7_inflight", 0); pop_check(64'(b0.rd_busy[0]));
    push("data7_byp", 32'h777); pop_check(64'(d0(0)));
    tick();
    b0.we = 0;
    #1;
    push("busy7_clr", 0); pop_check(64'(b0.rd_busy[0]));
    b0.iss_v = 1; b0.iss_rd = 5'd9;
    b0.we = 1; b0.wr_addr = 5'd9; b0.wr_data = 32'h99;
    b0.re = 2'b10; b0.rd_addr = {5'd9, 5'd0};
    tick();
    b0.iss_v = 0; b0.we = 0;
    #1;
    push("busy9_setwins", 1); pop_check(64'(b0.rd_busy[1]));
    push("busy9_p0_off", 0);  pop_check(64'(b0.rd_busy[0]));
    b0.we = 1; b0.wr_addr = 5'd9;
    tick();
    idle();
  endtask

  task automatic test_read_enable();
    b0.we = 1; b0.wr_addr = 5'd3; b0.wr_data = 32'h55;
    tick();
    b0.we = 0; b0.iss_v = 1; b0.iss_rd = 5'd3;
    tick();
    b0.iss_v = 0; b0.re = 2'b01; b0.rd_addr = {5'd3, 5'd3};
    #1;
    push("re_p0_data", 32'h55); pop_check(64'(d0(0)));
    push("re_p0_busy", 1);      pop_check(64'(b0.rd_busy[0]));
    push("re_p1_data", 0);      pop_check(64'(d0(1)));
    push("re_p1_busy", 0);      pop_check(64'(b0.rd_busy[1]));
    idle();
  endtask

  task automatic test_reset_mid();
    int z0, z1, z2;
    rst = 1; tick(); rst = 0;
    for (int c = 0; c < 12; c++) tick();
    rst = 1; tick(); rst = 0;
    count_sweep(z0, z1, z2);
    push("midsweep_len_32", 31); pop_check(64'(z0));
    push("midsweep_len_16", 15); pop_check(64'(z2));
    wait_ready(4);
    b1.we = 1; b1.wr_addr = 5'd4; b1.wr_data = 32'h1111;
    tick();
    b1.we = 0; b1.iss_v = 1; b1.iss_rd = 5'd6;
    b0.iss_v = 1; b0.iss_rd = 5'd6;
    tick();
    b1.iss_v = 0; b0.iss_v = 0;
    b1.re = 2'b01; b1.rd_addr = {5'd0, 5'd6};
    #1;
    push("pre_rst_busy6", 1); pop_check(64'(b1.rd_busy[0]));
    b1.we = 1; b1.wr_addr = 5'd4; b1.wr_data = 32'h4444;
    rst = 1;
    tick();
    rst = 0; b1.we = 0;
    tick();
    b1.re = 2'b11; b1.rd_addr = {5'd6, 5'd4};
    #1;
    push("rst_wr_dropped", 32'h1111); pop_check(64'(d1(0)));
    push("rst_busy6_b1", 0);          pop_check(64'(b1.rd_busy[1]));
    count_sweep(z0, z1, z2);
    wait_ready(4);
    b0.re = 2'b01; b0.rd_addr = {5'd0, 5'd6};
    #1;
    push("rst_busy6_b0", 0); pop_check(64'(b0.rd_busy[0]));
    idle();
  endtask

  task automatic test_param();
    logic [63:0] v [5];
    v[1] = 64'h1111_2222_3333_4444;
    v[2] = 64'hA5A5_0000_FFFF_1234;
    v[3] = 64'h0F0F_F0F0_0000_0003;
    v[4] = 64'h8000_0000_0000_0001;
    for (int r = 1; r < 5; r++) begin
      b2.we = 1; b2.wr_addr = 4'(r); b2.wr_data = v[r];
      tick();
    end
    b2.we = 0;
    b2.re = 4'b1111;
    for (int p = 0; p < 4; p++) b2.rd_addr[p*4 +: 4] = 4'(4 - p);
    #1;
    for (int p = 0; p < 4; p++) begin
      push($sformatf("p16_port%0d", p), v[4 - p]); pop_check(d2(p));
    end
    b2.we = 1; b2.wr_addr = 4'd15; b2.wr_data = ~v[2];
    b2.rd_addr[12 +: 4] = 4'd15;
    #1;
    push("p16_byp15", ~v[2]); pop_check(d2(3));
    tick();
    b2.we = 0;
    #1;
    push("p16_r15", ~v[2]); pop_check(d2(3));
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_bypass();
    test_scoreboard();
    test_read_enable();
    test_reset_mid();
    test_param();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    if (errors == 0) $display("PASS");
    else             $display("FAIL");
    $finish;
  end
endmodule
